project_cfg_ctrl: RTL and testbench
===================================

Name: project_cfg_ctrl

Overview:
- Wishbone-programmable project selector upstream of the user-project mux in the wrapper.
- Decodes CFG_ADDRESS and holds the active project index.
- On a select change it runs a safe switchover: gate all project clocks, hold them in reset, then enable the new project.
- Drives the mux select, per-project clock enables and per-project active-low resets consumed by the wrapper.

Parameters:
- CFG_ADDRESS, 32'h300FFFFC, word address of the config/status register.
- USER_PROJECTS, 4, number of selectable projects.
- CFG_BITS, $clog2(USER_PROJECTS), width of the select field.
- RESET_SEL, 0, project active after reset.
- HOLD_CYCLES, 4, cycles all projects are held gated and in reset during a switch (range 1..255).

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_ni  input  1  reset; synchronous, active-low.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  address.
- wbs_ack_o  output  1  ack for CFG_ADDRESS accesses only.
- wbs_dat_o  output  32  read data (status word).
- cfg_hit  output  1  combinational: adr==CFG_ADDRESS & cyc & stb; wrapper uses it to route ack/dat from this block.
- cfg_sel  output  CFG_BITS  registered mux select.
- proj_clk_en  output  USER_PROJECTS  registered clock enables, one-hot or zero.
- proj_rst_n  output  USER_PROJECTS  registered active-low project resets.
- busy  output  1  switchover in progress.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge) produces the following state:
  - cfg_sel=RESET_SEL; proj_clk_en=1<<RESET_SEL; proj_rst_n=0 (all).
  - wbs_ack_o=0; busy=0; lock=0; drop=0; err=0; state=WAKE.
  - The first cycle after reset release therefore behaves as WAKE.
- Status word (read):
  - [CFG_BITS-1:0]=cfg_sel; [8]=busy; [9]=drop; [10]=err; [16]=lock; all other bits 0.
- Bus handshake:
  - Access accepted when cfg_hit & ~wbs_ack_o.
  - wbs_ack_o registered, high exactly the cycle after acceptance, one cycle wide.
  - Back-to-back accesses are acked every other cycle.
  - wbs_dat_o is registered with the ack; 0 when not acking.
- Write handling (accepted cycle T, in priority order):
  - sel_i[2] & dat[16] sets lock. Lock is sticky until reset.
  - If sel_i[0]=0, the select field is unaffected.
  - If sel_i[0]=1, the requested value req=dat[CFG_BITS-1:0] is handled as follows:
    - lock already 1 before T: req ignored, no flag.
    - busy: req ignored; drop<=1.
    - req>=USER_PROJECTS: req ignored; err<=1.
    - req==cfg_sel: no-op.
    - otherwise: pend<=req and state<=QUIESCE at T+1.
- Read handling: a read returns the status then clears drop and err (read-to-clear). A write in the same cycle that sets a flag wins over the clear.
- FSM:
  - IDLE:
    - busy=0; proj_clk_en=1<<cfg_sel; proj_rst_n=1<<cfg_sel (inactive projects held in reset).
  - QUIESCE:
    - busy=1; proj_clk_en=0; proj_rst_n=0; counter loaded with HOLD_CYCLES-1.
    - Decrement each cycle; at 0, cfg_sel<=pend and go to WAKE.
  - WAKE, one cycle:
    - busy=1; proj_clk_en=1<<cfg_sel; proj_rst_n=0.
    - Then go to IDLE.
  - busy is high for HOLD_CYCLES+1 cycles, starting at T+1.
  - cfg_sel changes only on the QUIESCE->WAKE edge. All outputs change only at clock edges, with no glitches.
- Reset mid-switch: returns immediately to RESET_SEL per the reset values above. pend is discarded.
- Non-matching addresses: no ack and no state change; wbs_dat_o=0.

Decomposition:
- Package proj_cfg_pkg holds:
  - state enum (IDLE, QUIESCE, WAKE);
  - status bit positions (BUSY_BIT=8, DROP_BIT=9, ERR_BIT=10, LOCK_BIT=16);
  - the default CFG_ADDRESS constant.
- One sub-module: cfg_wb_regif, covering address decode, ack generation, the status read mux and the sticky flags.
- The FSM and counter stay in the top module.

Test Plan:
- Reset release, RESET_SEL=0: proj_clk_en=4'b0001; proj_rst_n=0 for 1 cycle, then 4'b0001; read status returns 0x0000_0000 with a 1-cycle ack.
- Write 0x2 with sel=4'hF at T: ack at T+1; busy T+1..T+5 (HOLD_CYCLES=4); proj_clk_en=0 for T+1..T+4; cfg_sel=2 at T+5; proj_rst_n=4'b0100 at T+6.
- Write 0x3 while busy: select unchanged, drop=1; status read returns bit9 set; next read returns it cleared.
- Set lock (bit16) and write 0x5 in one transaction with USER_PROJECTS=4: lock=1, err=1 from the out-of-range value, no switch. Then write 0x1: ignored, no new flag, cfg_sel unchanged.
- Assert wb_rst_ni=0 during QUIESCE after a write of 0x1: next edge gives cfg_sel=0, proj_clk_en=4'b0001, busy=0, lock=0.
- Access with wbs_adr_i=0x3000_0000: cfg_hit=0, no ack, no state change. Held stb on CFG_ADDRESS: ack pattern 1,0,1,0.

Source files
------------

// File: rtl/proj_cfg_pkg.sv
// Shared types and constants for the project configuration controller.
package proj_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        WAKE    = 2'd2
    } state_e;

    localparam int BUSY_BIT = 8;
    localparam int DROP_BIT = 9;
    localparam int ERR_BIT  = 10;
    localparam int LOCK_BIT = 16;

    localparam logic [31:0] CFG_ADDRESS_DEFAULT = 32'h300F_FFFC;

endpackage

// File: rtl/cfg_wb_regif.sv
// Wishbone register interface: address decode, single-cycle ack, status read-back,
// sticky lock/drop/err flags and qualification of select-change requests.
module cfg_wb_regif
    import proj_cfg_pkg::*;
#(
    parameter logic [31:0] CFG_ADDRESS   = CFG_ADDRESS_DEFAULT,
    parameter int          USER_PROJECTS = 4,
    parameter int          CFG_BITS      = $clog2(USER_PROJECTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic                busy,
    input  logic [CFG_BITS-1:0] cfg_sel,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                cfg_hit,
    output logic                switch_req,
    output logic [CFG_BITS-1:0] switch_val
);

    localparam logic [7:0] NPROJ = 8'(USER_PROJECTS);

    logic        accept, wr, rd;
    logic        lock, drop, err;
    logic        set_drop, set_err;
    logic [7:0]  req_wide;
    logic [31:0] status;
    logic        unused_bits;

    assign cfg_hit    = (wbs_adr_i == CFG_ADDRESS) & wbs_cyc_i & wbs_stb_i;
    assign accept     = cfg_hit & ~wbs_ack_o;
    assign wr         = accept & wbs_we_i;
    assign rd         = accept & ~wbs_we_i;
    assign req_wide   = wbs_dat_i[7:0];
    assign switch_val = req_wide[CFG_BITS-1:0];
    assign unused_bits = ^{wbs_sel_i[3], wbs_sel_i[1], wbs_dat_i[31:17], wbs_dat_i[15:8]};

    // The whole byte below the busy bit is the select field, so wide values are out of range.
    always_comb begin
        set_drop   = 1'b0;
        set_err    = 1'b0;
        switch_req = 1'b0;
        if (wr && wbs_sel_i[0] && !lock) begin
            if (busy)
                set_drop = 1'b1;
            else if (req_wide >= NPROJ)
                set_err = 1'b1;
            else if (switch_val != cfg_sel)
                switch_req = 1'b1;
        end
    end

    always_comb begin
        status                 = '0;
        status[CFG_BITS-1:0]   = cfg_sel;
        status[BUSY_BIT]       = busy;
        status[DROP_BIT]       = drop;
        status[ERR_BIT]        = err;
        status[LOCK_BIT]       = lock;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            lock      <= 1'b0;
            drop      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= accept ? status : '0;
            if (wr && wbs_sel_i[2] && wbs_dat_i[16])
                lock <= 1'b1;
            // A flag raised by this cycle's write takes precedence over read-to-clear.
            if (set_drop)
                drop <= 1'b1;
            else if (rd)
                drop <= 1'b0;
            if (set_err)
                err <= 1'b1;
            else if (rd)
                err <= 1'b0;
        end
    end

endmodule

// File: rtl/project_cfg_ctrl.sv
// Project selector: holds the active project index and sequences a gated,
// reset-held switchover before enabling the newly selected project.
module project_cfg_ctrl
    import proj_cfg_pkg::*;
#(
    parameter logic [31:0] CFG_ADDRESS   = CFG_ADDRESS_DEFAULT,
    parameter int          USER_PROJECTS = 4,
    parameter int          CFG_BITS      = $clog2(USER_PROJECTS),
    parameter int          RESET_SEL     = 0,
    parameter int          HOLD_CYCLES   = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic                     cfg_hit,
    output logic [CFG_BITS-1:0]      cfg_sel,
    output logic [USER_PROJECTS-1:0] proj_clk_en,
    output logic [USER_PROJECTS-1:0] proj_rst_n,
    output logic                     busy
);

    localparam logic [CFG_BITS-1:0] RST_SEL = CFG_BITS'(RESET_SEL);
    localparam logic [7:0]          HOLD_LD = 8'(HOLD_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [7:0]                 cnt_q;
    logic [CFG_BITS-1:0]        pend_q, sel_d;
    logic [USER_PROJECTS-1:0]   clk_en_d, rst_n_d;
    logic                       busy_d;
    logic                       switch_req;
    logic [CFG_BITS-1:0]        switch_val;

    function automatic logic [USER_PROJECTS-1:0] onehot(input logic [CFG_BITS-1:0] s);
        return {{(USER_PROJECTS-1){1'b0}}, 1'b1} << s;
    endfunction

    cfg_wb_regif #(
        .CFG_ADDRESS  (CFG_ADDRESS),
        .USER_PROJECTS(USER_PROJECTS),
        .CFG_BITS     (CFG_BITS)
    ) u_regif (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .busy      (busy),
        .cfg_sel   (cfg_sel),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .cfg_hit   (cfg_hit),
        .switch_req(switch_req),
        .switch_val(switch_val)
    );

    // Outputs are registered from the next state so they only ever move on a clock edge.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= WAKE;
            cfg_sel     <= RST_SEL;
            pend_q      <= RST_SEL;
            cnt_q       <= '0;
            proj_clk_en <= onehot(RST_SEL);
            proj_rst_n  <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_sel     <= sel_d;
            proj_clk_en <= clk_en_d;
            proj_rst_n  <= rst_n_d;
            busy        <= busy_d;
            if (switch_req) begin
                pend_q <= switch_val;
                cnt_q  <= HOLD_LD;
            end else if (state_q == QUIESCE && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    // A request can only arrive when not busy, i.e. in IDLE or the post-reset WAKE cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = cfg_sel;
        unique case (state_q)
            IDLE: begin
                if (switch_req)
                    state_d = QUIESCE;
            end
            QUIESCE: begin
                if (cnt_q == 8'd0) begin
                    state_d = WAKE;
                    sel_d   = pend_q;
                end
            end
            WAKE: begin
                state_d = switch_req ? QUIESCE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d   = (state_d != IDLE);
        clk_en_d = (state_d == QUIESCE) ? '0 : onehot(sel_d);
        rst_n_d  = (state_d == IDLE) ? onehot(sel_d) : '0;
    end

endmodule

// File: tb/tb_project_cfg_ctrl.sv
// Self-checking bench for project_cfg_ctrl: directed scenarios plus randomized
// traffic compared against a switch-timeline reference model.
module tb_project_cfg_ctrl;

    localparam logic [31:0] CFG = 32'h300F_FFFC;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        ack, hit, busy;
    logic [31:0] dat_o;
    logic [1:0]  cfg_sel;
    logic [3:0]  clk_en, prst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: age counts cycles since the accepted switch write (0 = no switch).
    int          m_age = 0;
    logic [1:0]  m_sel = 2'd0, m_pend = 2'd0;
    logic        m_lock = 0, m_drop = 0, m_err = 0, m_after_rst = 0, m_ack = 0;
    logic [31:0] m_dat = '0;

    project_cfg_ctrl #(
        .CFG_ADDRESS(CFG), .USER_PROJECTS(4), .CFG_BITS(2), .RESET_SEL(0), .HOLD_CYCLES(HOLD)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .cfg_hit(hit), .cfg_sel(cfg_sel),
        .proj_clk_en(clk_en), .proj_rst_n(prst_n), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    function automatic logic exp_busy();
        return m_age != 0;
    endfunction
    function automatic logic [3:0] exp_clk_en();
        return (m_age >= 1 && m_age <= HOLD) ? 4'b0000 : oh(m_sel);
    endfunction
    function automatic logic [3:0] exp_rst_n();
        return (m_age != 0 || m_after_rst) ? 4'b0000 : oh(m_sel);
    endfunction

    task automatic model_edge();
        logic acc, busy_prev, old_lock;
        logic [31:0] status;
        if (!rst_n) begin
            m_age = 0; m_sel = 2'd0; m_lock = 0; m_drop = 0; m_err = 0;
            m_after_rst = 1; m_ack = 0; m_dat = '0;
            return;
        end
        busy_prev = (m_age != 0);
        acc = (adr == CFG) && cyc && stb && !m_ack;
        status = {15'd0, m_lock, 5'd0, m_err, m_drop, busy_prev, 6'd0, m_sel};
        m_ack = acc;
        m_dat = acc ? status : 32'd0;
        old_lock = m_lock;
        if (m_age != 0) begin
            m_age++;
            if (m_age == HOLD + 1) m_sel = m_pend;
            else if (m_age > HOLD + 1) m_age = 0;
        end
        m_after_rst = 0;
        if (acc && !we) begin
            m_drop = 0;
            m_err  = 0;
        end
        if (acc && we) begin
            if (sel[2] && dat[16]) m_lock = 1;
            if (sel[0] && !old_lock) begin
                if (busy_prev) m_drop = 1;
                else if (dat[7:0] >= 8'd4) m_err = 1;
                else if (dat[1:0] != m_sel) begin
                    m_pend = dat[1:0];
                    m_age  = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic w, input logic [3:0] s, input logic [31:0] d, input logic [31:0] a);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d; adr = a;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat = '0; adr = '0;
    endtask

    task automatic test_reset();
        bus_idle();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({cfg_sel, clk_en, prst_n, busy, ack} !== {2'd0, 4'b0001, 4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: sel=%0d clk_en=%b rst_n=%b busy=%b ack=%b, want 0 0001 0000 0 0",
                     cfg_sel, clk_en, prst_n, busy, ack);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (prst_n !== 4'b0001 || clk_en !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release: rst_n=%b clk_en=%b, want 0001 0001", prst_n, clk_en);
        end
        bus(1'b0, 4'hF, '0, CFG);
        tick();
        n_checks++;
        if (ack !== 1'b1 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status_read: ack=%b dat=%h, want 1 00000000", ack, dat_o);
        end
        bus_idle();
        tick();
        n_checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ack_width: ack=%b dat=%h, want 0 00000000", ack, dat_o);
        end
    endtask

    task automatic test_switch();
        logic       e_busy;
        logic [3:0] e_clk, e_rst;
        logic [1:0] e_sel;
        bus(1'b1, 4'hF, 32'h2, CFG);
        tick();
        n_checks++;
        if (ack !== 1'b1 || busy !== 1'b1 || clk_en !== 4'b0000 || cfg_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL switch_t1: ack=%b busy=%b clk_en=%b sel=%0d, want 1 1 0000 0", ack, busy, clk_en, cfg_sel);
        end
        bus_idle();
        for (int k = 2; k <= 6; k++) begin
            tick();
            e_busy = (k <= 5);
            e_sel  = (k >= 5) ? 2'd2 : 2'd0;
            e_clk  = (k >= 5) ? 4'b0100 : 4'b0000;
            e_rst  = (k == 6) ? 4'b0100 : 4'b0000;
            n_checks++;
            if ({busy, cfg_sel, clk_en, prst_n} !== {e_busy, e_sel, e_clk, e_rst}) begin
                n_fail++;
                $display("FAIL switch_t%0d: busy=%b sel=%0d clk_en=%b rst_n=%b, want %b %0d %b %b",
                         k, busy, cfg_sel, clk_en, prst_n, e_busy, e_sel, e_clk, e_rst);
            end
        end
    endtask

    task automatic test_drop();
        int guard;
        bus(1'b1, 4'hF, 32'h1, CFG); tick();
        bus_idle(); tick();
        bus(1'b1, 4'hF, 32'h3, CFG); tick();
        bus_idle();
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        tick();
        n_checks++;
        if (guard >= 20 || cfg_sel !== 2'd1 || prst_n !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_select: sel=%0d rst_n=%b guard=%0d, want 1 0010 <20", cfg_sel, prst_n, guard);
        end
        bus(1'b0, 4'hF, '0, CFG); tick();
        n_checks++;
        if (dat_o !== 32'h0000_0201) begin
            n_fail++;
            $display("FAIL drop_flag_read: dat=%h, want 00000201", dat_o);
        end
        bus_idle(); tick();
        bus(1'b0, 4'hF, '0, CFG); tick();
        n_checks++;
        if (dat_o !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL drop_clear_read: dat=%h, want 00000001", dat_o);
        end
        bus_idle(); tick();
    endtask

    task automatic test_lock_err();
        bus(1'b1, 4'hF, 32'h0001_0005, CFG); tick();
        bus_idle(); tick();
        n_checks++;
        if (busy !== 1'b0 || cfg_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL lock_no_switch: busy=%b sel=%0d, want 0 1", busy, cfg_sel);
        end
        bus(1'b0, 4'hF, '0, CFG); tick();
        n_checks++;
        if (dat_o !== 32'h0001_0401) begin
            n_fail++;
            $display("FAIL lock_err_read: dat=%h, want 00010401", dat_o);
        end
        bus_idle(); tick();
        bus(1'b1, 4'hF, 32'h0, CFG); tick();
        bus_idle(); tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || cfg_sel !== 2'd1 || clk_en !== 4'b0010) begin
            n_fail++;
            $display("FAIL locked_write: busy=%b sel=%0d clk_en=%b, want 0 1 0010", busy, cfg_sel, clk_en);
        end
        bus(1'b0, 4'hF, '0, CFG); tick();
        n_checks++;
        if (dat_o !== 32'h0001_0001) begin
            n_fail++;
            $display("FAIL locked_status: dat=%h, want 00010001", dat_o);
        end
        bus_idle(); tick();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        bus(1'b0, 4'hF, '0, CFG); tick();
        n_checks++;
        if (dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_clears_lock: dat=%h, want 00000000", dat_o);
        end
        bus_idle(); tick();
        bus(1'b1, 4'hF, 32'h1, CFG); tick();
        bus_idle(); tick();
        n_checks++;
        if (busy !== 1'b1 || clk_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_quiesce: busy=%b clk_en=%b, want 1 0000", busy, clk_en);
        end
        rst_n = 1'b0; tick();
        n_checks++;
        if ({cfg_sel, clk_en, busy, prst_n} !== {2'd0, 4'b0001, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL mid_reset: sel=%0d clk_en=%b busy=%b rst_n=%b, want 0 0001 0 0000",
                     cfg_sel, clk_en, busy, prst_n);
        end
        rst_n = 1'b1; tick(); tick(); tick();
        n_checks++;
        if ({cfg_sel, clk_en, busy, prst_n} !== {2'd0, 4'b0001, 1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL pend_discarded: sel=%0d clk_en=%b busy=%b rst_n=%b, want 0 0001 0 0001",
                     cfg_sel, clk_en, busy, prst_n);
        end
    endtask

    task automatic test_nonmatch();
        logic e_ack;
        bus(1'b1, 4'hF, 32'h3, 32'h3000_0000);
        #1;
        n_checks++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmatch_hit: cfg_hit=%b, want 0", hit);
        end
        tick();
        bus_idle(); tick();
        n_checks++;
        if ({ack, dat_o, busy, cfg_sel} !== {1'b0, 32'h0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL nonmatch_state: ack=%b dat=%h busy=%b sel=%0d, want 0 0 0 0", ack, dat_o, busy, cfg_sel);
        end
        bus(1'b0, 4'hF, '0, CFG);
        #1;
        n_checks++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("FAIL match_hit: cfg_hit=%b, want 1", hit);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            e_ack = (i % 2 == 0);
            n_checks++;
            if (ack !== e_ack) begin
                n_fail++;
                $display("FAIL held_ack_%0d: ack=%b, want %b", i, ack, e_ack);
            end
        end
        bus_idle(); tick();
    endtask

    task automatic test_random();
        logic e_hit;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 1) == 1) begin
                cyc = 1'b1; stb = 1'b1;
                we  = $urandom_range(0, 1);
                sel = 4'($urandom_range(0, 15));
                dat = $urandom;
                dat[7:0] = 8'($urandom_range(0, 5));
                dat[16]  = ($urandom_range(0, 59) == 0);
                adr = ($urandom_range(0, 3) != 0) ? CFG : $urandom;
            end else begin
                bus_idle();
            end
            #1;
            e_hit = (adr == CFG) && cyc && stb;
            n_checks++;
            if (hit !== e_hit) begin
                n_fail++;
                $display("FAIL rnd_hit[%0d]: cfg_hit=%b, want %b", n, hit, e_hit);
            end
            tick();
            n_checks++;
            if ({cfg_sel, clk_en, prst_n, busy} !== {m_sel, exp_clk_en(), exp_rst_n(), exp_busy()}) begin
                n_fail++;
                $display("FAIL rnd_ctrl[%0d]: sel=%0d clk_en=%b rst_n=%b busy=%b, want %0d %b %b %b",
                         n, cfg_sel, clk_en, prst_n, busy, m_sel, exp_clk_en(), exp_rst_n(), exp_busy());
            end
            n_checks++;
            if (ack !== m_ack || dat_o !== m_dat) begin
                n_fail++;
                $display("FAIL rnd_bus[%0d]: ack=%b dat=%h, want %b %h", n, ack, dat_o, m_ack, m_dat);
            end
        end
        rst_n = 1'b1;
        bus_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_switch();
        test_drop();
        test_lock_err();
        test_reset_mid();
        test_nonmatch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
